// File: rtl/cnn_layer_accel_job_master_pkg.sv
// Shared types and sizing for the CNN layer accelerator job master.
package cnn_layer_accel_job_pkg;

  localparam int PARAM_W                = 128;
  localparam int WORDS_W                = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_FETCH,
    ST_STREAM,
    ST_WAIT_COMPLETE,
    ST_ERROR
  } job_state_t;

endpackage

// File: rtl/cnn_layer_accel_job_master_skid_buf.sv
// Two-entry skid buffer: one-cycle latency, sustains one word per cycle.
module cnn_layer_accel_skid_buf #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign level     = cnt;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_master.sv
// Job master: hands a job to the quad, streams its pixel words, collects completion.
// Optional watchdog/ERROR state enabled by defining JOB_MASTER_TIMEOUT_EN.
module cnn_layer_accel_job_master
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk_if,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PARAM_W-1:0] cmd_params,
  input  logic [WORDS_W-1:0] cmd_num_words,
  output logic               job_start,
  input  logic               job_accept,
  output logic [PARAM_W-1:0] job_parameters,
  input  logic               job_fetch_request,
  output logic               job_fetch_ack,
  output logic               job_fetch_complete,
  input  logic               job_complete,
  output logic               job_complete_ack,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [PARAM_W-1:0] src_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic [PARAM_W-1:0] pixel_data,
  output logic               done,
  output logic               busy,
  output logic               err_timeout
);

  job_state_t         state;
  job_state_t         state_next;
  logic               armed;
  logic [WORDS_W-1:0] word_cnt;
  logic               zero_pend;
  logic               zero_pend_next;
  logic               fetch_ack_next;
  logic               fetch_complete_next;
  logic               complete_ack_next;
  logic               done_next;
  logic               cmd_fire;
  logic               xfer;
  logic               last_xfer;
  logic               buf_in_valid;
  logic               buf_in_ready;
  logic [1:0]         buf_level;

  // armed keeps cmd_ready low until the first clock edge out of reset;
  // masking with done defers a command that collides with the done pulse.
  assign cmd_ready    = (state == ST_IDLE) && armed && !done;
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign job_start    = (state == ST_START);
  assign busy         = (state != ST_IDLE);
  assign xfer         = pixel_valid && pixel_ready;
  assign last_xfer    = (state == ST_STREAM) && xfer && (word_cnt == WORDS_W'(1));
  // Words already buffered count against the remaining budget, so no word
  // beyond the job length is ever taken from the source.
  assign src_ready    = (state == ST_STREAM) && buf_in_ready &&
                        (word_cnt > WORDS_W'(buf_level));
  assign buf_in_valid = src_valid && src_ready;

  cnn_layer_accel_skid_buf #(
    .DATA_W(PARAM_W)
  ) u_skid (
    .clk      (clk_if),
    .rst_n    (rst_n),
    .in_valid (buf_in_valid),
    .in_ready (buf_in_ready),
    .in_data  (src_data),
    .out_valid(pixel_valid),
    .out_ready(pixel_ready),
    .out_data (pixel_data),
    .level    (buf_level)
  );

`ifdef JOB_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd;
  logic            watched;
  logic            wd_hit;
  logic            err_q;

  assign watched     = (state == ST_START) || (state == ST_WAIT_FETCH) ||
                       (state == ST_WAIT_COMPLETE);
  assign wd_hit      = watched && (wd == WD_W'(C_TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_next != state) wd <= '0;
      else if (watched)        wd <= wd + WD_W'(1);
      if (state_next == ST_ERROR) err_q <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_next          = state;
    zero_pend_next      = 1'b0;
    fetch_ack_next      = 1'b0;
    fetch_complete_next = zero_pend;
    complete_ack_next   = 1'b0;
    done_next           = 1'b0;
    unique case (state)
      ST_IDLE: if (cmd_fire) state_next = ST_START;
      ST_START: if (job_accept) state_next = ST_WAIT_FETCH;
      ST_WAIT_FETCH: begin
        if (job_fetch_request) begin
          fetch_ack_next = 1'b1;
          if (word_cnt == '0) begin
            zero_pend_next = 1'b1;
            state_next     = ST_WAIT_COMPLETE;
          end else begin
            state_next = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (last_xfer) begin
          fetch_complete_next = 1'b1;
          state_next          = ST_WAIT_COMPLETE;
        end
      end
      ST_WAIT_COMPLETE: begin
        if (job_complete) begin
          complete_ack_next = 1'b1;
          done_next         = 1'b1;
          state_next        = ST_IDLE;
        end
      end
`ifdef JOB_MASTER_TIMEOUT_EN
      ST_ERROR: state_next = ST_ERROR;
`endif
      default: state_next = ST_IDLE;
    endcase
`ifdef JOB_MASTER_TIMEOUT_EN
    if (wd_hit && (state_next == state)) state_next = ST_ERROR;
`endif
  end

  always_ff @(posedge clk_if) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      armed              <= 1'b0;
      job_parameters     <= '0;
      word_cnt           <= '0;
      zero_pend          <= 1'b0;
      job_fetch_ack      <= 1'b0;
      job_fetch_complete <= 1'b0;
      job_complete_ack   <= 1'b0;
      done               <= 1'b0;
    end else begin
      armed              <= 1'b1;
      zero_pend          <= zero_pend_next;
      job_fetch_ack      <= fetch_ack_next;
      job_fetch_complete <= fetch_complete_next;
      job_complete_ack   <= complete_ack_next;
      done               <= done_next;
      if (cmd_fire) begin
        job_parameters <= cmd_params;
        word_cnt       <= cmd_num_words;
      end else if ((state == ST_STREAM) && xfer) begin
        word_cnt <= word_cnt - WORDS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_master.sv
// Scoreboard bench for cnn_layer_accel_job_master; watchdog case needs JOB_MASTER_TIMEOUT_EN.
module tb_cnn_layer_accel_job_master;

  localparam int TO = 32;

  logic         clk_if = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [127:0] cmd_params = '0;
  logic [15:0]  cmd_num_words = '0;
  logic         job_start;
  logic         job_accept = 1'b0;
  logic [127:0] job_parameters;
  logic         job_fetch_request = 1'b0;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete = 1'b0;
  logic         job_complete_ack;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [127:0] src_data = '0;
  logic         pixel_valid;
  logic         pixel_ready = 1'b0;
  logic [127:0] pixel_data;
  logic         done;
  logic         busy;
  logic         err_timeout;

  cnn_layer_accel_job_master #(.C_TIMEOUT_CYCLES(TO)) dut (
    .clk_if(clk_if), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_params(cmd_params),
    .cmd_num_words(cmd_num_words),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
    .done(done), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk_if = ~clk_if;

  int cyc = 0;
  always @(posedge clk_if) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_px[$];
  logic [127:0] src_q[$];
  int exp_ack[$], exp_fc[$], exp_cack[$], exp_done[$], exp_start_len[$];
  int px_left = 0;
  int px_seen = 0;
  int start_run = 0;
  bit ready_toggle = 1'b0;
  bit take;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_chk(input string name, ref int q[$]);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected pulse at cycle %0d, required none", name, cyc);
    end else begin
      int e;
      e = q.pop_front();
      check(name, cyc, e);
    end
  endtask

  function automatic logic [127:0] word(input int base, input int i);
    logic [31:0] w;
    w = 32'(base + i);
    return {w, ~w, w, ~w};
  endfunction

  // Monitor: pops expected pulses/pixels as the DUT presents them.
  initial forever begin
    @(negedge clk_if);
    if (job_fetch_ack)      pulse_chk("fetch_ack", exp_ack);
    if (job_fetch_complete) pulse_chk("fetch_complete", exp_fc);
    if (job_complete_ack)   pulse_chk("complete_ack", exp_cack);
    if (done)               pulse_chk("done", exp_done);
    if (pixel_valid && pixel_ready) begin
      if (exp_px.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pixel unexpected word %0h at cycle %0d, required none", pixel_data, cyc);
      end else begin
        check("pixel_data", pixel_data, exp_px.pop_front());
      end
      px_seen++;
      if (px_left > 0) begin
        px_left--;
        if (px_left == 0) exp_fc.push_back(cyc + 1);
      end
    end
    if (job_start) start_run++;
    else if (start_run > 0) begin
      if (exp_start_len.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL job_start_len unexpected run %0d, required none", start_run);
      end else begin
        check("job_start_len", start_run, exp_start_len.pop_front());
      end
      start_run = 0;
    end
  end

  // Source and pixel_ready driver.
  initial forever begin
    @(negedge clk_if);
    take = src_valid && src_ready;
    @(posedge clk_if);
    #1;
    if (take && src_q.size() > 0) void'(src_q.pop_front());
    src_valid   = (src_q.size() > 0);
    src_data    = src_valid ? src_q[0] : '0;
    pixel_ready = ready_toggle ? !pixel_ready : 1'b1;
  end

  task automatic send_cmd(input int base, input int n, output int start_cyc);
    bit r;
    int guard;
    logic [127:0] p;
    p = word(base, 4242);
    for (int i = 0; i < n; i++) begin
      exp_px.push_back(word(base, i));
      src_q.push_back(word(base, i));
    end
    src_q.push_back(word(base, 1000));
    px_left = n;
    px_seen = 0;
    cmd_valid = 1'b1;
    cmd_params = p;
    cmd_num_words = 16'(n);
    r = 1'b0;
    guard = 0;
    while (!r && guard < 50) begin
      @(negedge clk_if);
      r = cmd_ready;
      @(posedge clk_if);
      #1;
      guard++;
    end
    cmd_valid = 1'b0;
    start_cyc = cyc;
    check("cmd_accepted", r, 1'b1);
    check("job_parameters", job_parameters, p);
  endtask

  task automatic accept_after(input int d);
    exp_start_len.push_back(d);
    repeat (d - 1) begin @(posedge clk_if); #1; end
    job_accept = 1'b1;
    @(posedge clk_if);
    #1;
    job_accept = 1'b0;
    job_complete = 1'b0;
    job_fetch_request = 1'b0;
  endtask

  task automatic fetch_after(input int d, input int n);
    repeat (d) begin @(posedge clk_if); #1; end
    job_fetch_request = 1'b1;
    exp_ack.push_back(cyc + 1);
    if (n == 0) exp_fc.push_back(cyc + 2);
    @(posedge clk_if);
    #1;
    job_fetch_request = 1'b0;
  endtask

  task automatic wait_stream(input int n);
    int g;
    g = 0;
    while (!(px_left == 0 && exp_fc.size() == 0) && g < 300) begin
      @(negedge clk_if);
      #1;
      g++;
    end
    check("stream_finished", g < 300, 1'b1);
    check("pixels_delivered", px_seen, n);
    @(posedge clk_if);
    #1;
  endtask

  task automatic complete_after(input int d, output int done_cyc);
    repeat (d) begin @(posedge clk_if); #1; end
    job_complete = 1'b1;
    exp_cack.push_back(cyc + 1);
    exp_done.push_back(cyc + 1);
    done_cyc = cyc + 1;
    @(posedge clk_if);
    #1;
    job_complete = 1'b0;
  endtask

  task automatic close_job();
    check("pixels_pending", exp_px.size(), 0);
    check("extra_word_held", src_q.size(), 1);
    src_q.delete();
  endtask

  task automatic idle_checks();
    @(negedge clk_if);
    #1;
    check("pulses_pending",
          exp_ack.size() + exp_fc.size() + exp_cack.size() + exp_done.size() + exp_start_len.size(), 0);
    check("busy_idle", busy, 1'b0);
  endtask

  function automatic logic [9:0] ctl_outs();
    return {cmd_ready, job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
            src_ready, pixel_valid, done, busy, err_timeout};
  endfunction

  int s, dc, g;

  initial begin
    // Reset state
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("reset_ctl_outs", ctl_outs(), '0);
    check("reset_job_parameters", job_parameters, '0);
    check("reset_pixel_data", pixel_data, '0);
    @(posedge clk_if);
    #1;
    rst_n = 1'b1;
    @(negedge clk_if);
    check("cmd_ready_before_first_edge", cmd_ready, 1'b0);
    @(negedge clk_if);
    check("cmd_ready_after_release", cmd_ready, 1'b1);

    // Spurious handshake inputs in IDLE
    @(posedge clk_if);
    #1;
    job_complete = 1'b1; job_fetch_request = 1'b1; job_accept = 1'b1;
    repeat (3) begin
      @(negedge clk_if);
      check("idle_spurious_state", {busy, job_start}, 2'b00);
    end
    @(posedge clk_if);
    #1;
    job_complete = 1'b0; job_fetch_request = 1'b0; job_accept = 1'b0;

    // Nominal job
    send_cmd(100, 8, s);
    accept_after(3);
    fetch_after(2, 8);
    wait_stream(8);
    complete_after(10, dc);
    close_job();
    idle_checks();

    // Spurious inputs while in START
    send_cmd(200, 3, s);
    job_complete = 1'b1;
    job_fetch_request = 1'b1;
    accept_after(3);
    fetch_after(1, 3);
    wait_stream(3);
    complete_after(2, dc);
    close_job();
    idle_checks();

    // Backpressure, then a command presented during the done pulse
    ready_toggle = 1'b1;
    send_cmd(300, 16, s);
    accept_after(1);
    fetch_after(0, 16);
    wait_stream(16);
    complete_after(2, dc);
    close_job();
    ready_toggle = 1'b0;
    send_cmd(400, 0, s);
    check("cmd_after_done_start_cycle", s, dc + 2);

    // Zero words
    accept_after(2);
    fetch_after(1, 0);
    wait_stream(0);
    complete_after(1, dc);
    close_job();
    idle_checks();

    // Reset in the middle of streaming
    send_cmd(500, 8, s);
    accept_after(1);
    fetch_after(0, 8);
    g = 0;
    while (px_seen < 4 && g < 100) begin
      @(negedge clk_if);
      #1;
      g++;
    end
    check("midreset_reached_stream", g < 100, 1'b1);
    @(posedge clk_if);
    #1;
    rst_n = 1'b0;
    @(posedge clk_if);
    #1;
    exp_px.delete();
    src_q.delete();
    px_left = 0;
    @(negedge clk_if);
    check("midreset_ctl_outs", ctl_outs(), '0);
    check("midreset_job_parameters", job_parameters, '0);
    check("midreset_pixel_data", pixel_data, '0);
    @(posedge clk_if);
    #1;
    rst_n = 1'b1;
    @(negedge clk_if);
    @(negedge clk_if);
    check("midreset_cmd_ready", cmd_ready, 1'b1);
    check("midreset_no_pulses", exp_ack.size() + exp_fc.size() + exp_cack.size() + exp_done.size(), 0);
    @(posedge clk_if);
    #1;

    // New job after reset
    send_cmd(600, 5, s);
    accept_after(2);
    fetch_after(1, 5);
    wait_stream(5);
    complete_after(3, dc);
    close_job();
    idle_checks();

`ifdef JOB_MASTER_TIMEOUT_EN
    // Watchdog: job_accept never arrives
    send_cmd(700, 1, s);
    exp_start_len.push_back(TO);
    repeat (TO) begin @(posedge clk_if); #1; end
    @(negedge clk_if);
    check("wd_err_timeout", err_timeout, 1'b1);
    check("wd_job_start", job_start, 1'b0);
    check("wd_cmd_ready_busy", {cmd_ready, busy}, 2'b01);
    repeat (10) @(negedge clk_if);
    check("wd_sticky_outs", ctl_outs(), 10'b0000000011);
    @(posedge clk_if);
    #1;
    rst_n = 1'b0;
    @(posedge clk_if);
    #1;
    exp_px.delete();
    src_q.delete();
    px_left = 0;
    @(negedge clk_if);
    check("wd_reset_clears", ctl_outs(), '0);
    @(posedge clk_if);
    #1;
    rst_n = 1'b1;
    @(negedge clk_if);
    @(negedge clk_if);
`else
    @(negedge clk_if);
    check("err_timeout_tied", err_timeout, 1'b0);
`endif

    repeat (3) @(posedge clk_if);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
